// File: rtl/jk_drv_pkg.sv
// Shared types and constants for the JK flip-flop excitation driver.
// Holds the FSM state type, the {J,K} excitation encodings and default sizes.
package jk_drv_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  // {J,K} pairs; don't-care entries resolve to 0 so toggle is never produced
  localparam logic [1:0] EXC_HOLD  = 2'b00;
  localparam logic [1:0] EXC_SET   = 2'b10;
  localparam logic [1:0] EXC_RESET = 2'b01;

  function automatic logic [1:0] jk_excitation(input logic q, input logic q_next);
    case ({q, q_next})
      2'b01:   return EXC_SET;
      2'b10:   return EXC_RESET;
      default: return EXC_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation: inverse of the JK characteristic function,
// mapping (current Q, requested next Q) to (J, K).
module jk_excite
  import jk_drv_pkg::*;
(
  input  logic i_q,
  input  logic i_q_next,
  output logic o_j,
  output logic o_k
);

  logic [1:0] w_jk;

  assign w_jk = jk_excitation(i_q, i_q_next);
  assign o_j  = w_jk[1];
  assign o_k  = w_jk[0];

endmodule

// File: rtl/jk_excite_driver.sv
// Drives a JK flip-flop bank to a requested word: accept, excite for one cycle, check.
// Define JK_DRV_CHECK_EN to enable the Q-vs-target comparator, err pulse and err_cnt.
module jk_excite_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 CP,
  input  logic                 n_rst,
  input  logic                 tgt_valid,
  input  logic [WIDTH-1:0]     tgt_data,
  output logic                 tgt_ready,
  input  logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     J,
  output logic [WIDTH-1:0]     K,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_t           r_state;
  state_t           w_next;
  logic             r_ready;
  logic             r_done;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_accept;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exc
    jk_excite u_exc (
      .i_q      (Q[gi]),
      .i_q_next (tgt_data[gi]),
      .o_j      (w_j[gi]),
      .o_k      (w_k[gi])
    );
  end

  // r_ready is low out of reset, so the state check alone is not enough
  assign w_accept = (r_state == IDLE) && tgt_valid && r_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = DRIVE;
      DRIVE:   w_next = CHECK;
      CHECK:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CP or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_j     <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == IDLE);
      r_done  <= (r_state == CHECK);
      // Excitation exists only for the DRIVE cycle; every other cycle holds
      if (w_accept) begin
        r_j <= w_j;
        r_k <= w_k;
      end else begin
        r_j <= '0;
        r_k <= '0;
      end
    end
  end

  assign tgt_ready = r_ready;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign J         = r_j;
  assign K         = r_k;

`ifdef JK_DRV_CHECK_EN
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]     r_tgt;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_mismatch;

  assign w_mismatch = (r_state == CHECK) && (Q != r_tgt);

  always_ff @(posedge CP or negedge n_rst) begin
    if (!n_rst) begin
      r_tgt     <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_tgt <= tgt_data;
      end
      r_err <= w_mismatch;
      if (w_mismatch && (r_err_cnt != CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign err     = r_err;
  assign err_cnt = r_err_cnt;
`else
  assign err     = 1'b0;
  assign err_cnt = '0;
`endif

endmodule
